// File: rtl/rr_arb_mux_nx1.sv
// rtl/rr_arb_mux_nx1.sv - N-channel round-robin arbitrating mux with valid/ready and registered output
// Optional packet lock: define RR_ARB_MUX_LOCK_EN to add in_last and hold the grant until the last beat.
module rr_arb_mux_nx1 #(
  parameter int N = 4,
  parameter int W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0][W-1:0]   in_data,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]          in_last,
`endif
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic [$clog2(N)-1:0]  out_sel,
  input  logic                  out_ready
);

  localparam int SELW = $clog2(N);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
  logic            lock_q,      lock_d;
`endif

  logic            can_load;
  logic            grant_any;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] next_ptr;
  logic            xfer;

  // The output stage can take a new beat when empty or being drained this cycle.
  assign can_load = !out_valid_q || out_ready;
  // Reset low blocks every transfer so no producer sees in_ready while the mux is held in reset.
  assign xfer     = reset && can_load && grant_any;
  // Priority after a grant to g is g+1, wrapping by explicit compare so non-power-of-2 N works.
  assign next_ptr = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin search starting at rr_ptr; a one-bit-wider index keeps the modulo sum from overflowing.
  always_comb begin
    logic [SELW:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
      if (!grant_any && in_valid[idx[SELW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[SELW-1:0];
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    // Mid-packet, only the owning channel (the last one transferred) may be granted.
    if (lock_q) begin
      grant_any = in_valid[out_sel_q];
      grant_idx = out_sel_q;
    end
`endif
  end

  // One-hot accept to the granted channel only when the beat will actually be taken.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // Output stage and priority pointer next-state; stalled grants leave rr_ptr untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx];
      out_sel_d   = grant_idx;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_d      = !in_last[grant_idx];
      if (in_last[grant_idx]) rr_ptr_d = next_ptr;
`else
      rr_ptr_d    = next_ptr;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards any held beat immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
